axi_read_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the core's single AXI read-address/read-data channel pair. The instruction-fetch requester (port 0) and the data-load requester (port 1) each issue burst read requests. The block grants one of them round-robin, drives the AR channel, and steers R beats back to the granted requester until the last beat. Only one burst is outstanding at a time. The block sits between the fetch/LSU front ends and the top-level m_axi_ar*/m_axi_r* ports.

---
 rtl/axi_arb_pkg.sv | 20 ++
 rtl/rr_arb2.sv | 20 ++
 rtl/axi_read_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_axi_read_arbiter.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_arb_pkg.sv
// Shared types and AXI encodings for the two-requester AXI read arbiter.
package axi_arb_pkg;

  // Sequencer states: arbitrate, present AR, steer R beats
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_t;

  localparam logic [2:0] AXI_SIZE_8B    = 3'd3;
  localparam logic [1:0] AXI_BURST_WRAP = 2'b10;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  // Increment an 8-bit beat counter, holding at 255 instead of wrapping
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : (v + 8'd1);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant. Purely combinational; the parent holds last_grant.
module rr_arb2 (
  input  logic [1:0] i_req,
  input  logic       i_last_grant,
  output logic       o_valid,
  output logic       o_grant
);

  // Sole requester wins; on a tie the requester not served last wins
  always_comb begin
    o_valid = |i_req;
    case (i_req)
      2'b01:   o_grant = 1'b0;
      2'b10:   o_grant = 1'b1;
      2'b11:   o_grant = ~i_last_grant;
      default: o_grant = 1'b0;
    endcase
  end

endmodule

// File: rtl/axi_read_arbiter.sv
// Arbitrates fetch (port 0) and load (port 1) burst reads onto one AXI AR/R
// channel pair, one burst outstanding at a time, and steers R beats back to
// the granted requester. Flags length and ID anomalies as sticky errors.
module axi_read_arbiter
  import axi_arb_pkg::*;
#(
  parameter int ID_WIDTH   = 13,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [1:0]                 req_valid,
  input  logic [1:0][ADDR_WIDTH-1:0] req_addr,
  input  logic [1:0][7:0]            req_len,
  output logic [1:0]                 req_ready,
  output logic [1:0]                 rsp_valid,
  output logic [1:0][DATA_WIDTH-1:0] rsp_data,
  output logic [1:0]                 rsp_last,
  output logic [1:0][1:0]            rsp_resp,
  input  logic [1:0]                 rsp_ready,
  output logic [ID_WIDTH-1:0]        m_axi_arid,
  output logic [ADDR_WIDTH-1:0]      m_axi_araddr,
  output logic [7:0]                 m_axi_arlen,
  output logic [2:0]                 m_axi_arsize,
  output logic [1:0]                 m_axi_arburst,
  output logic                       m_axi_arvalid,
  input  logic                       m_axi_arready,
  input  logic [ID_WIDTH-1:0]        m_axi_rid,
  input  logic [DATA_WIDTH-1:0]      m_axi_rdata,
  input  logic [1:0]                 m_axi_rresp,
  input  logic                       m_axi_rlast,
  input  logic                       m_axi_rvalid,
  output logic                       m_axi_rready,
  output logic                       err_len,
  output logic                       err_id
);

  arb_state_t            r_state;
  arb_state_t            w_next_state;
  logic                  r_grant;
  logic                  r_last_grant;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_len;
  logic                  r_arvalid;
  logic [7:0]            r_beat_cnt;
  logic                  r_err_len;
  logic                  r_err_id;

  logic                  w_arb_valid;
  logic                  w_arb_grant;
  logic [ID_WIDTH-1:0]   w_grant_id;
  logic                  w_id_match;
  logic                  w_ar_hs;
  logic                  w_r_hs;
  logic                  w_good_hs;
  logic                  w_bad_hs;
  logic                  w_orphan_hs;

  rr_arb2 u_rr_arb2 (
    .i_req        (req_valid),
    .i_last_grant (r_last_grant),
    .o_valid      (w_arb_valid),
    .o_grant      (w_arb_grant)
  );

  assign w_grant_id  = {{(ID_WIDTH-1){1'b0}}, r_grant};
  assign w_id_match  = (m_axi_rid == w_grant_id);
  assign w_ar_hs     = r_arvalid && m_axi_arready;
  assign w_r_hs      = m_axi_rvalid && m_axi_rready;
  assign w_good_hs   = (r_state == DATA) && w_id_match && w_r_hs;
  assign w_bad_hs    = (r_state == DATA) && !w_id_match && w_r_hs;
  assign w_orphan_hs = (r_state == IDLE) && w_r_hs;

  assign m_axi_arid    = w_grant_id;
  assign m_axi_araddr  = r_addr;
  assign m_axi_arlen   = r_len;
  assign m_axi_arsize  = AXI_SIZE_8B;
  assign m_axi_arburst = AXI_BURST_WRAP;
  assign m_axi_arvalid = r_arvalid;
  assign err_len       = r_err_len;
  assign err_id        = r_err_id;

  // Beat payload is broadcast; only the granted port's rsp_valid qualifies it
  assign rsp_data[0] = m_axi_rdata;
  assign rsp_data[1] = m_axi_rdata;
  assign rsp_last    = {2{m_axi_rlast}};
  assign rsp_resp[0] = m_axi_rresp;
  assign rsp_resp[1] = m_axi_rresp;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state: accept a request, wait for AR handshake, run until rlast
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_arb_valid) w_next_state = ADDR;
        else             w_next_state = IDLE;
      end
      ADDR: begin
        if (w_ar_hs) w_next_state = DATA;
        else         w_next_state = ADDR;
      end
      DATA: begin
        if (w_good_hs && m_axi_rlast) w_next_state = IDLE;
        else                          w_next_state = DATA;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Handshake outputs: request accept in IDLE, R steering in DATA
  always_comb begin
    req_ready    = 2'b00;
    rsp_valid    = 2'b00;
    m_axi_rready = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_arb_valid) req_ready[w_arb_grant] = 1'b1;
        else             req_ready = 2'b00;
        // Swallow stray beats left over from a dropped burst
        m_axi_rready = m_axi_rvalid;
      end
      ADDR: begin
        m_axi_rready = 1'b0;
      end
      DATA: begin
        if (w_id_match) begin
          rsp_valid[r_grant] = m_axi_rvalid;
          m_axi_rready       = rsp_ready[r_grant];
        end else begin
          m_axi_rready = 1'b1;
        end
      end
      default: begin
        m_axi_rready = 1'b0;
      end
    endcase
  end

  // Burst context, AR valid, beat counter, round-robin history and errors
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_addr       <= '0;
      r_len        <= 8'd0;
      r_arvalid    <= 1'b0;
      r_beat_cnt   <= 8'd0;
      r_err_len    <= 1'b0;
      r_err_id     <= 1'b0;
    end else begin
      if ((r_state == IDLE) && w_arb_valid) begin
        r_grant <= w_arb_grant;
        r_addr  <= req_addr[w_arb_grant];
        r_len   <= req_len[w_arb_grant];
      end
      r_arvalid <= (w_next_state == ADDR);
      if (w_ar_hs) begin
        r_beat_cnt <= 8'd0;
      end else if (w_good_hs) begin
        r_beat_cnt <= sat_inc8(r_beat_cnt);
      end
      if (w_good_hs && m_axi_rlast) begin
        r_last_grant <= r_grant;
        if (r_beat_cnt != r_len) r_err_len <= 1'b1;
      end
      if (w_bad_hs || w_orphan_hs) r_err_id <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Randomized self-checking bench for axi_read_arbiter. The bench acts as both
// requesters and the AXI slave; expectations come from a transaction-level
// model (who should win, what AR must carry, which beats must appear where).
module tb_axi_read_arbiter;

  localparam int IDW = 13;
  localparam int AW  = 64;
  localparam int DW  = 64;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [1:0]           req_valid;
  logic [1:0][AW-1:0]   req_addr;
  logic [1:0][7:0]      req_len;
  logic [1:0]           req_ready;
  logic [1:0]           rsp_valid;
  logic [1:0][DW-1:0]   rsp_data;
  logic [1:0]           rsp_last;
  logic [1:0][1:0]      rsp_resp;
  logic [1:0]           rsp_ready;
  logic [IDW-1:0]       m_axi_arid;
  logic [AW-1:0]        m_axi_araddr;
  logic [7:0]           m_axi_arlen;
  logic [2:0]           m_axi_arsize;
  logic [1:0]           m_axi_arburst;
  logic                 m_axi_arvalid;
  logic                 m_axi_arready;
  logic [IDW-1:0]       m_axi_rid;
  logic [DW-1:0]        m_axi_rdata;
  logic [1:0]           m_axi_rresp;
  logic                 m_axi_rlast;
  logic                 m_axi_rvalid;
  logic                 m_axi_rready;
  logic                 err_len;
  logic                 err_id;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit [1:0] want;       // requesters currently asking for a burst
  bit [1:0] cont;       // requesters that immediately re-request after acceptance
  bit       m_last;     // requester served most recently
  bit       m_err_len;
  bit       m_err_id;

  typedef struct {
    logic [63:0] data;
    logic        last;
    logic        good;
    logic [1:0]  resp;
  } beat_t;

  axi_read_arbiter #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_addr      (req_addr),
    .req_len       (req_len),
    .req_ready     (req_ready),
    .rsp_valid     (rsp_valid),
    .rsp_data      (rsp_data),
    .rsp_last      (rsp_last),
    .rsp_resp      (rsp_resp),
    .rsp_ready     (rsp_ready),
    .m_axi_arid    (m_axi_arid),
    .m_axi_araddr  (m_axi_araddr),
    .m_axi_arlen   (m_axi_arlen),
    .m_axi_arsize  (m_axi_arsize),
    .m_axi_arburst (m_axi_arburst),
    .m_axi_arvalid (m_axi_arvalid),
    .m_axi_arready (m_axi_arready),
    .m_axi_rid     (m_axi_rid),
    .m_axi_rdata   (m_axi_rdata),
    .m_axi_rresp   (m_axi_rresp),
    .m_axi_rlast   (m_axi_rlast),
    .m_axi_rvalid  (m_axi_rvalid),
    .m_axi_rready  (m_axi_rready),
    .err_len       (err_len),
    .err_id        (err_id)
  );

  // Free-running clock, 10 ns period
  always #5 clk = ~clk;

  // Hard time limit so the run always ends
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_reset_state();
    check("rst_req_ready", req_ready, 2'b00);
    check("rst_rsp_valid", rsp_valid, 2'b00);
    check("rst_arvalid", m_axi_arvalid, 1'b0);
    check("rst_rready", m_axi_rready, 1'b0);
    check("rst_araddr", m_axi_araddr, 64'd0);
    check("rst_arlen", m_axi_arlen, 8'd0);
    check("rst_arid", m_axi_arid, 13'd0);
    check("rst_err_len", err_len, 1'b0);
    check("rst_err_id", err_id, 1'b0);
  endtask

  // Quiet cycles with no requests: nothing may be granted or forwarded
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      req_valid     = 2'b00;
      m_axi_rvalid  = 1'b0;
      m_axi_arready = 1'b0;
      #1;
      check("idle_req_ready", req_ready, 2'b00);
      check("idle_arvalid", m_axi_arvalid, 1'b0);
      check("idle_rsp_valid", rsp_valid, 2'b00);
      check("idle_err_len", err_len, m_err_len);
      check("idle_err_id", err_id, m_err_id);
    end
  endtask

  // A stray R beat while idle: must be consumed and flagged, never forwarded
  task automatic orphan();
    @(posedge clk); #1;
    req_valid    = 2'b00;
    m_axi_rvalid = 1'b1;
    m_axi_rid    = 13'h5;
    m_axi_rlast  = 1'b1;
    m_axi_rdata  = {$urandom, $urandom};
    #1;
    check("orphan_rready", m_axi_rready, 1'b1);
    check("orphan_rsp_valid", rsp_valid, 2'b00);
    m_err_id = 1'b1;
  endtask

  // One complete burst starting in an idle cycle.
  //   n_beats  : good beats the slave returns (negative: arlen+1)
  //   bad_pos  : insert a wrong-ID beat before this good beat (-1: none)
  //   ar_stall : cycles arready stays low
  //   bp_mode  : 0 always ready, 1 random gaps/backpressure, 2 three-cycle stall at beat 3
  //   rst_at   : assert reset once this many good beats are delivered (-1: never)
  task automatic burst(input int n_beats, input int bad_pos, input int ar_stall,
                       input int bp_mode, input int rst_at);
    bit          g;
    bit          rdy;
    logic [63:0] ex_addr;
    logic [7:0]  ex_len;
    logic [IDW-1:0] gid;
    beat_t       q[$];
    beat_t       b;
    int          good_done;
    int          cyc;
    int          bp_left;
    bit          bp_used;

    g = (want == 2'b11) ? ~m_last : want[1];

    // Request cycle: the winner must be accepted right away
    @(posedge clk); #1;
    req_valid     = want;
    m_axi_rvalid  = 1'b0;
    m_axi_arready = 1'b0;
    rsp_ready     = 2'b11;
    #1;
    check("req_ready", req_ready, 2'b01 << g);
    check("req_err_len", err_len, m_err_len);
    check("req_err_id", err_id, m_err_id);
    check("req_arvalid", m_axi_arvalid, 1'b0);
    ex_addr = req_addr[g];
    ex_len  = req_len[g];
    gid     = IDW'(g);
    if (n_beats < 0) n_beats = int'(ex_len) + 1;
    if (!cont[g]) want[g] = 1'b0;

    // Address phase: AR held stable until arready
    for (int s = 0; s <= ar_stall; s++) begin
      @(posedge clk); #1;
      req_valid     = want;
      m_axi_arready = (s == ar_stall);
      #1;
      check("arvalid", m_axi_arvalid, 1'b1);
      check("araddr", m_axi_araddr, ex_addr);
      check("arlen", m_axi_arlen, ex_len);
      check("arid", m_axi_arid, gid);
      check("addr_req_ready", req_ready, 2'b00);
    end
    check("arsize", m_axi_arsize, 3'd3);
    check("arburst", m_axi_arburst, 2'b10);

    for (int k = 0; k < n_beats; k++) begin
      if (k == bad_pos) begin
        b.data = {$urandom, $urandom};
        b.last = 1'($urandom_range(0, 1));
        b.good = 1'b0;
        b.resp = 2'($urandom_range(0, 3));
        q.push_back(b);
      end
      b.data = {$urandom, $urandom};
      b.last = (k == n_beats - 1);
      b.good = 1'b1;
      b.resp = 2'($urandom_range(0, 3));
      q.push_back(b);
    end

    // Data phase
    good_done = 0;
    cyc       = 0;
    bp_left   = 0;
    bp_used   = 1'b0;
    while (q.size() > 0) begin
      cyc++;
      if (cyc > 2000) begin
        check("r_timeout_beats_left", 64'(q.size()), 64'd0);
        break;
      end
      @(posedge clk); #1;
      req_valid     = want;
      m_axi_arready = 1'b0;
      if (rst_at == good_done) begin
        reset        = 1'b0;
        m_axi_rvalid = 1'b0;
        req_valid    = 2'b00;
        want         = 2'b00;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check_reset_state();
        m_last    = 1'b1;
        m_err_len = 1'b0;
        m_err_id  = 1'b0;
        return;
      end
      b            = q[0];
      m_axi_rvalid = (bp_mode != 1) || ($urandom_range(0, 3) != 0);
      m_axi_rdata  = b.data;
      m_axi_rlast  = b.last;
      m_axi_rresp  = b.resp;
      m_axi_rid    = b.good ? gid : (gid ^ 13'h0100);
      rdy = 1'b1;
      if (bp_mode == 1) rdy = 1'($urandom_range(0, 1));
      if (bp_mode == 2) begin
        if (!bp_used && good_done == 3) begin
          bp_used = 1'b1;
          bp_left = 3;
        end
        if (bp_left > 0) begin
          rdy = 1'b0;
          bp_left--;
        end
      end
      rsp_ready[g]  = rdy;
      rsp_ready[~g] = 1'($urandom_range(0, 1));
      #1;
      check("data_req_ready", req_ready, 2'b00);
      check("rsp_valid_other", rsp_valid[~g], 1'b0);
      if (!m_axi_rvalid) begin
        check("rsp_valid_gap", rsp_valid[g], 1'b0);
      end else if (b.good) begin
        check("rsp_valid", rsp_valid[g], 1'b1);
        check("rready", m_axi_rready, rdy);
        check("rsp_data", rsp_data[g], b.data);
        check("rsp_last", rsp_last[g], b.last);
        check("rsp_resp", rsp_resp[g], b.resp);
        if (rdy) begin
          void'(q.pop_front());
          good_done++;
        end
      end else begin
        check("bad_rsp_valid", rsp_valid[g], 1'b0);
        check("bad_rready", m_axi_rready, 1'b1);
        void'(q.pop_front());
        m_err_id = 1'b1;
      end
    end
    m_last = g;
    if (n_beats != int'(ex_len) + 1) m_err_len = 1'b1;
  endtask

  initial begin
    reset         = 1'b0;
    req_valid     = 2'b00;
    req_addr      = '0;
    req_len       = '0;
    rsp_ready     = 2'b00;
    m_axi_arready = 1'b0;
    m_axi_rvalid  = 1'b0;
    m_axi_rid     = '0;
    m_axi_rdata   = '0;
    m_axi_rresp   = 2'b00;
    m_axi_rlast   = 1'b0;
    want          = 2'b00;
    cont          = 2'b00;
    m_last        = 1'b1;
    m_err_len     = 1'b0;
    m_err_id      = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_reset_state();

    // Single fetch burst
    want        = 2'b01;
    req_addr[0] = 64'h1000;
    req_len[0]  = 8'd7;
    burst(8, -1, 0, 0, -1);
    idle_cycles(2);

    // Consumer backpressure mid-burst
    want        = 2'b01;
    req_addr[0] = {$urandom, $urandom};
    req_len[0]  = 8'd7;
    burst(8, -1, 0, 2, -1);

    // AR stall on the load port
    want        = 2'b10;
    req_addr[1] = {$urandom, $urandom};
    req_len[1]  = 8'd3;
    burst(-1, -1, 5, 1, -1);
    idle_cycles(1);

    // Random traffic: requesters join independently, addresses stable while pending
    for (int it = 0; it < 16; it++) begin
      for (int i = 0; i < 2; i++) begin
        if (!want[i] && ($urandom_range(0, 1) == 1)) begin
          want[i]     = 1'b1;
          req_addr[i] = {$urandom, $urandom};
          req_len[i]  = 8'($urandom_range(0, 15));
        end
      end
      if (want == 2'b00) begin
        want[0]     = 1'b1;
        req_addr[0] = {$urandom, $urandom};
        req_len[0]  = 8'($urandom_range(0, 15));
      end
      burst(-1, -1, $urandom_range(0, 3), 1, -1);
    end
    while (want != 2'b00) burst(-1, -1, 0, 1, -1);
    idle_cycles(1);

    // Continuous contention: grants must alternate
    cont        = 2'b11;
    want        = 2'b11;
    req_addr[0] = 64'h2000;
    req_addr[1] = 64'h3000;
    req_len[0]  = 8'd3;
    req_len[1]  = 8'd1;
    for (int it = 0; it < 4; it++) burst(-1, -1, $urandom_range(0, 2), 1, -1);
    cont = 2'b00;
    want = 2'b00;
    idle_cycles(2);

    // Short burst with a wrong-ID beat: both sticky errors
    want        = 2'b01;
    req_addr[0] = 64'h4000;
    req_len[0]  = 8'd7;
    burst(4, 2, 0, 0, -1);
    idle_cycles(1);

    // Errors stay set through a clean burst
    want        = 2'b10;
    req_addr[1] = 64'h5000;
    req_len[1]  = 8'd1;
    burst(2, -1, 0, 0, -1);
    idle_cycles(1);

    // Reset after beat 3, then a stray beat, then the first tie goes to port 0
    want        = 2'b01;
    req_addr[0] = 64'h6000;
    req_len[0]  = 8'd7;
    burst(8, -1, 0, 0, 3);
    orphan();
    want        = 2'b11;
    req_addr[0] = 64'h7000;
    req_addr[1] = 64'h8000;
    req_len[0]  = 8'd2;
    req_len[1]  = 8'd2;
    burst(-1, -1, 0, 0, -1);
    burst(-1, -1, 0, 0, -1);
    idle_cycles(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
